// File: rtl/anc_audio_rx.sv
// I2S slave receiver feeding the ANC controller. The left word becomes the x(n) RAM
// write and the right word becomes e(n). Each accepted left+right pair gives one frame-done pulse.
module anc_audio_rx #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrck,
  input  logic                    i2s_sdata,
  input  logic                    anc_ready,
  output logic [SAMPLE_WIDTH-1:0] xn_wdata,
  output logic                    xn_wren,
  output logic [SAMPLE_WIDTH-1:0] en,
  output logic                    audio_rx_down,
  output logic                    rx_overrun
);

  localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
  localparam int IDX_W = $clog2(SAMPLE_WIDTH);

  logic bclk_meta_q, bclk_meta_d, bclk_sync_q, bclk_sync_d, bclk_dly_q, bclk_dly_d;
  logic lrck_meta_q, lrck_meta_d, lrck_s_q, lrck_s_d;
  logic sdata_meta_q, sdata_meta_d, sdata_s_q, sdata_s_d;
  logic bclk_rise;

  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    lrck_prev_q, lrck_prev_d;
  logic                    synced_q, synced_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    left_valid_q, left_valid_d;
  logic [SAMPLE_WIDTH-1:0] xn_wdata_q, xn_wdata_d;
  logic [SAMPLE_WIDTH-1:0] en_q, en_d;
  logic                    xn_wren_q, xn_wren_d;
  logic                    rx_down_q, rx_down_d;
  logic                    rx_overrun_q, rx_overrun_d;

  logic [SAMPLE_WIDTH-1:0] word;
  logic [IDX_W-1:0]        wr_idx;

  assign bclk_rise = bclk_sync_q & ~bclk_dly_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    bclk_meta_d  = i2s_bclk;
    bclk_sync_d  = bclk_meta_q;
    bclk_dly_d   = bclk_sync_q;
    lrck_meta_d  = i2s_lrck;
    lrck_s_d     = lrck_meta_q;
    sdata_meta_d = i2s_sdata;
    sdata_s_d    = sdata_meta_q;

    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    lrck_prev_d  = lrck_prev_q;
    synced_d     = synced_q;
    left_hold_d  = left_hold_q;
    left_valid_d = left_valid_q;
    xn_wdata_d   = xn_wdata_q;
    en_d         = en_q;
    xn_wren_d    = 1'b0;
    rx_down_d    = 1'b0;
    rx_overrun_d = rx_overrun_q;
    word         = shreg_q;
    wr_idx       = '0;

    if (bclk_rise) begin
      lrck_prev_d = lrck_s_q;
      if (int'(bit_cnt_q) < SAMPLE_WIDTH) begin
        wr_idx          = IDX_W'(SAMPLE_WIDTH - 1 - int'(bit_cnt_q));
        shreg_d[wr_idx] = sdata_s_q;
        bit_cnt_d       = bit_cnt_q + 1'b1;
      end

      if (lrck_s_q != lrck_prev_q) begin
        word      = shreg_d;
        shreg_d   = '0;
        bit_cnt_d = '0;
        synced_d  = 1'b1;
        // Until the first channel change after reset, bits belong to a word whose start
        // we never saw. That change only aligns the receiver and completes nothing.
        if (synced_q) begin
          if (!lrck_prev_q) begin
            left_hold_d  = word;
            left_valid_d = 1'b1;
          end else if (left_valid_q) begin
            left_valid_d = 1'b0;
            if (anc_ready) begin
              xn_wdata_d = left_hold_q;
              en_d       = word;
              xn_wren_d  = 1'b1;
              rx_down_d  = 1'b1;
            end else begin
              rx_overrun_d = 1'b1;
            end
          end
        end
      end else if (!synced_q) begin
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_meta_q  <= 1'b0;
      bclk_sync_q  <= 1'b0;
      bclk_dly_q   <= 1'b0;
      lrck_meta_q  <= 1'b0;
      lrck_s_q     <= 1'b0;
      sdata_meta_q <= 1'b0;
      sdata_s_q    <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      lrck_prev_q  <= 1'b0;
      synced_q     <= 1'b0;
      left_hold_q  <= '0;
      left_valid_q <= 1'b0;
      xn_wdata_q   <= '0;
      en_q         <= '0;
      xn_wren_q    <= 1'b0;
      rx_down_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      bclk_meta_q  <= bclk_meta_d;
      bclk_sync_q  <= bclk_sync_d;
      bclk_dly_q   <= bclk_dly_d;
      lrck_meta_q  <= lrck_meta_d;
      lrck_s_q     <= lrck_s_d;
      sdata_meta_q <= sdata_meta_d;
      sdata_s_q    <= sdata_s_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      lrck_prev_q  <= lrck_prev_d;
      synced_q     <= synced_d;
      left_hold_q  <= left_hold_d;
      left_valid_q <= left_valid_d;
      xn_wdata_q   <= xn_wdata_d;
      en_q         <= en_d;
      xn_wren_q    <= xn_wren_d;
      rx_down_q    <= rx_down_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign xn_wdata      = xn_wdata_q;
  assign en            = en_q;
  assign xn_wren       = xn_wren_q;
  assign audio_rx_down = rx_down_q;
  assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_anc_audio_rx.sv
// Bench for anc_audio_rx: directed I2S frames with literal expectations plus a random
// stream, both checked against a bit-stream model of the word and frame rules.
module tb_anc_audio_rx;

  localparam int SW = 16;

  typedef struct packed {
    logic [SW-1:0] x;
    logic [SW-1:0] e;
  } frame_t;

  logic          clk;
  logic          rst_n;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_sdata;
  logic          anc_ready;
  logic [SW-1:0] xn_wdata;
  logic          xn_wren;
  logic [SW-1:0] en;
  logic          audio_rx_down;
  logic          rx_overrun;

  anc_audio_rx #(.SAMPLE_WIDTH(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .anc_ready    (anc_ready),
    .xn_wdata     (xn_wdata),
    .xn_wren      (xn_wren),
    .en           (en),
    .audio_rx_down(audio_rx_down),
    .rx_overrun   (rx_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;
  int n_pulses = 0;

  // Model state: the bits of the word in flight, the pending left word, accepted frames.
  bit            m_synced;
  bit            m_prev;
  bit            m_left_valid;
  bit            m_overrun;
  logic [SW-1:0] m_left;
  bit            m_bits[$];
  frame_t        exp_q[$];
  logic [SW-1:0] last_x;
  logic [SW-1:0] last_e;
  bit            tail_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // First SW bits of the word, MSB first; short words are padded with zeros.
  function automatic logic [SW-1:0] justify();
    logic [SW-1:0] w;
    w = '0;
    for (int i = 0; i < SW && i < m_bits.size(); i++) w[SW-1-i] = m_bits[i];
    return w;
  endfunction

  task automatic model_rise(input bit ch, input bit d);
    logic [SW-1:0] w;
    m_bits.push_back(d);
    if (ch != m_prev) begin
      if (m_synced) begin
        w = justify();
        if (!m_prev) begin
          m_left       = w;
          m_left_valid = 1'b1;
        end else if (m_left_valid) begin
          m_left_valid = 1'b0;
          if (anc_ready) exp_q.push_back('{x: m_left, e: w});
          else m_overrun = 1'b1;
        end
      end
      m_synced = 1'b1;
      m_bits.delete();
    end else if (!m_synced) begin
      m_bits.delete();
    end
    m_prev = ch;
  endtask

  // One slot of n bclks on channel ch. Its first bit carries the LSB of the previous
  // word, and anc_ready takes rdy right after that bit.
  task automatic send_slot(input bit ch, input logic [31:0] v, input int n, input bit rdy);
    bit d;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? tail_bit : v[n-k];
      i2s_bclk = 1'b0;
      #5;
      i2s_lrck  = ch;
      i2s_sdata = d;
      #35;
      i2s_bclk = 1'b1;
      model_rise(ch, d);
      #40;
      if (k == 0) anc_ready = rdy;
    end
    tail_bit = v[0];
  endtask

  task automatic send_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv,
                            input int rn, input bit rdy);
    send_slot(1'b0, lv, ln, rdy);
    send_slot(1'b1, rv, rn, rdy);
  endtask

  task automatic do_reset();
    i2s_bclk = 1'b0;
    #10;
    rst_n = 1'b0;
    m_synced = 1'b0;
    m_prev = 1'b0;
    m_left_valid = 1'b0;
    m_overrun = 1'b0;
    m_left = '0;
    m_bits.delete();
    exp_q.delete();
    last_x = '0;
    last_e = '0;
    #1;
    check("rst_xn_wdata", xn_wdata, 0);
    check("rst_en", en, 0);
    check("rst_xn_wren", xn_wren, 0);
    check("rst_rx_down", audio_rx_down, 0);
    check("rst_overrun", rx_overrun, 0);
    #29;
    rst_n = 1'b1;
    #20;
  endtask

  // Per-cycle compare: pulses pair up and carry the next model frame; data holds otherwise.
  always @(negedge clk) begin : monitor
    frame_t f;
    if (rst_n) begin
      check("pulse_pair", audio_rx_down, xn_wren);
      if (xn_wren) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          f = exp_q.pop_front();
          last_x = f.x;
          last_e = f.e;
        end
      end
      check("xn_wdata", xn_wdata, last_x);
      check("en", en, last_e);
    end
  end

  int p0;
  logic [31:0] lv, rv;
  int ln, rn;
  bit rdy;

  initial begin
    rst_n = 1'b0;
    i2s_bclk = 1'b0;
    i2s_lrck = 1'b0;
    i2s_sdata = 1'b0;
    anc_ready = 1'b0;
    tail_bit = 1'b0;
    last_x = '0;
    last_e = '0;
    #2;

    // Basic capture
    do_reset();
    p0 = n_pulses;
    send_slot(1'b1, 32'h0, 4, 1'b1);
    send_frame(32'h1234, 16, 32'h8001, 16, 1'b1);
    send_slot(1'b0, 32'h0, 2, 1'b1);
    #100;
    check("basic_pulses", n_pulses - p0, 1);
    check("basic_x", xn_wdata, 16'h1234);
    check("basic_e", en, 16'h8001);
    check("basic_overrun", rx_overrun, 0);

    // Long words
    do_reset();
    send_slot(1'b1, 32'h5, 3, 1'b1);
    send_frame(32'hABCDEF, 24, 32'h7FFF00, 24, 1'b1);
    send_slot(1'b0, 32'h0, 2, 1'b1);
    #100;
    check("long_x", xn_wdata, 16'hABCD);
    check("long_e", en, 16'h7FFF);

    // Short words
    do_reset();
    send_slot(1'b1, 32'h3, 3, 1'b1);
    send_frame(32'hFFF, 12, 32'h800, 12, 1'b1);
    send_slot(1'b0, 32'h0, 2, 1'b1);
    #100;
    check("short_x", xn_wdata, 16'hFFF0);
    check("short_e", en, 16'h8000);

    // Overrun
    do_reset();
    p0 = n_pulses;
    send_slot(1'b1, 32'h0, 4, 1'b1);
    send_frame(32'h1111, 16, 32'h2222, 16, 1'b1);
    send_frame(32'h3333, 16, 32'h4444, 16, 1'b0);
    send_slot(1'b0, 32'h0, 2, 1'b0);
    #100;
    check("ovr_pulses", n_pulses - p0, 1);
    check("ovr_x", xn_wdata, 16'h1111);
    check("ovr_e", en, 16'h2222);
    check("ovr_flag", rx_overrun, 1);
    #400;
    check("ovr_sticky", rx_overrun, 1);
    do_reset();
    check("ovr_cleared", rx_overrun, 0);

    // Alignment: stream starts in the middle of a right word
    p0 = n_pulses;
    send_slot(1'b1, 32'h5A5, 9, 1'b1);
    send_frame(32'h0F0F, 16, 32'h7070, 16, 1'b1);
    send_slot(1'b0, 32'h0, 2, 1'b1);
    #100;
    check("align_pulses", n_pulses - p0, 1);
    check("align_x", xn_wdata, 16'h0F0F);
    check("align_e", en, 16'h7070);

    // Reset during the left word of frame 2
    do_reset();
    send_slot(1'b1, 32'h0, 4, 1'b1);
    send_frame(32'h1357, 16, 32'h2468, 16, 1'b1);
    send_slot(1'b0, 32'h9999, 7, 1'b1);
    check("pre_rst_x", xn_wdata, 16'h1357);
    do_reset();
    p0 = n_pulses;
    send_slot(1'b0, 32'h0AB, 9, 1'b1);
    send_slot(1'b1, 32'h1111, 16, 1'b1);
    check("rst_orphan_pulses", n_pulses - p0, 0);
    send_frame(32'h0ACE, 16, 32'h0BDF, 16, 1'b1);
    send_slot(1'b0, 32'h0, 2, 1'b1);
    #100;
    check("rst_pulses", n_pulses - p0, 1);
    check("rst_x", xn_wdata, 16'h0ACE);
    check("rst_e", en, 16'h0BDF);

    // Random stream: mixed word lengths and controller readiness
    do_reset();
    send_slot(1'b1, $urandom, 5, 1'b1);
    for (int f = 0; f < 40; f++) begin
      lv  = $urandom;
      rv  = $urandom;
      ln  = $urandom_range(10, 24);
      rn  = $urandom_range(10, 24);
      rdy = ($urandom_range(0, 3) != 0);
      send_frame(lv, ln, rv, rn, rdy);
      check("overrun_track", rx_overrun, m_overrun);
    end
    send_slot(1'b0, 32'h0, 2, anc_ready);
    #200;
    check("queue_drained", exp_q.size(), 0);
    check("overrun_final", rx_overrun, m_overrun);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
